// File: rtl/car_motion.sv
// Car motion controller: moves the car one floor per TRAVEL_CYCLES enabled
// cycles, decides at each floor whether to stop, and pulses the button clears
// for the requests it has served.
module car_motion #(
  parameter int TRAVEL_CYCLES = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  nextDirection,
  input  logic        doorState,
  input  logic [13:0] floorButton,
  input  logic [9:1]  internalButton,
  output logic [2:0]  currentFloor,
  output logic [1:0]  currentDirection,
  output logic        move,
  output logic        arrive,
  output logic [13:0] clearFloor,
  output logic [9:1]  clearInternal
);

  localparam int            CW         = $clog2(TRAVEL_CYCLES);
  localparam logic [CW-1:0] RELOAD     = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LEN = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRAVEL,
    S_SETTLE
  } state_t;

  typedef enum logic [1:0] {
    DIR_STOP = 2'b00,
    DIR_DOWN = 2'b01,
    DIR_UP   = 2'b10
  } dir_t;

  state_t        state_q, state_d;
  dir_t          dir_q, dir_d;
  logic [2:0]    floor_q, floor_d;
  logic          move_q, move_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          arrive_q, arrive_d;
  logic [13:0]   clr_floor_q, clr_floor_d;
  logic [9:1]    clr_int_q, clr_int_d;

  // Per-floor request vectors, bit k = floor k+1
  logic [6:0] hall_up, hall_dn, car_req, req_all;
  logic       unused_ib;

  assign hall_up   = {floorButton[13], floorButton[11], floorButton[9], floorButton[7],
                      floorButton[5], floorButton[3], floorButton[1]};
  assign hall_dn   = {floorButton[12], floorButton[10], floorButton[8], floorButton[6],
                      floorButton[4], floorButton[2], floorButton[0]};
  assign car_req   = internalButton[7:1];
  assign req_all   = hall_up | hall_dn | car_req;
  assign unused_ib = ^internalButton[9:8];

  logic        going_up;
  logic [2:0]  next_floor, f_idx;
  logic        beyond, endpoint, hall_match, hall_any, no_beyond_stop, stop, clear_both;
  logic [13:0] up_bit, dn_bit;

  // Stop test and clear masks evaluated at the floor the car is about to reach
  always_comb begin
    going_up   = (dir_q == DIR_UP);
    next_floor = going_up ? floor_q + 3'd1 : floor_q - 3'd1;
    f_idx      = next_floor - 3'd1;
    beyond     = 1'b0;
    for (int unsigned k = 0; k < 7; k++) begin
      if (going_up ? (k > 32'(f_idx)) : (k < 32'(f_idx)))
        beyond = beyond | req_all[k[2:0]];
    end
    endpoint       = going_up ? (next_floor == 3'd7) : (next_floor == 3'd1);
    hall_match     = going_up ? hall_up[f_idx] : hall_dn[f_idx];
    hall_any       = hall_up[f_idx] | hall_dn[f_idx];
    no_beyond_stop = hall_any & ~beyond;
    stop           = car_req[f_idx] | hall_match | no_beyond_stop | endpoint;
    clear_both     = endpoint | no_beyond_stop;
    up_bit         = 14'd2 << {f_idx, 1'b0};
    dn_bit         = 14'd1 << {f_idx, 1'b0};
  end

  // Next-state logic; everything holds and pulses drop while enable is low
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    floor_d     = floor_q;
    move_d      = move_q;
    cnt_d       = cnt_q;
    arrive_d    = 1'b0;
    clr_floor_d = '0;
    clr_int_d   = '0;
    if (enable) begin
      unique case (state_q)
        S_IDLE: begin
          if (!doorState &&
              ((nextDirection == DIR_UP && floor_q != 3'd7) ||
               (nextDirection == DIR_DOWN && floor_q != 3'd1))) begin
            dir_d   = dir_t'(nextDirection);
            move_d  = 1'b1;
            cnt_d   = RELOAD;
            state_d = S_TRAVEL;
          end
        end
        S_TRAVEL: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            floor_d = next_floor;
            if (stop) begin
              move_d      = 1'b0;
              arrive_d    = 1'b1;
              clr_int_d   = 9'd1 << f_idx;
              clr_floor_d = (going_up ? up_bit : dn_bit) | (clear_both ? (up_bit | dn_bit) : '0);
              cnt_d       = SETTLE_LEN;
              state_d     = S_SETTLE;
            end else begin
              cnt_d = RELOAD;
            end
          end
        end
        S_SETTLE: begin
          // Two cycles: counter runs 1 -> 0, then back to IDLE
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else             state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dir_q       <= DIR_STOP;
      floor_q     <= 3'd1;
      move_q      <= 1'b0;
      cnt_q       <= '0;
      arrive_q    <= 1'b0;
      clr_floor_q <= '0;
      clr_int_q   <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      floor_q     <= floor_d;
      move_q      <= move_d;
      cnt_q       <= cnt_d;
      arrive_q    <= arrive_d;
      clr_floor_q <= clr_floor_d;
      clr_int_q   <= clr_int_d;
    end
  end

  assign currentFloor     = floor_q;
  assign currentDirection = dir_q;
  assign move             = move_q;
  assign arrive           = arrive_q & enable;
  assign clearFloor       = clr_floor_q & {14{enable}};
  assign clearInternal    = clr_int_q & {9{enable}};

endmodule

// File: tb/tb_car_motion.sv
// Directed bench for car_motion with TRAVEL_CYCLES=4.
module tb_car_motion;

  localparam logic [1:0]  ST = 2'b00;
  localparam logic [1:0]  UP = 2'b10;
  localparam logic [1:0]  DN = 2'b01;
  localparam logic [13:0] FULL = 14'h3FFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [1:0]  nextDirection = ST;
  logic        doorState = 1'b0;
  logic [13:0] floorButton = '0;
  logic [9:1]  internalButton = '0;
  logic [2:0]  currentFloor;
  logic [1:0]  currentDirection;
  logic        move;
  logic        arrive;
  logic [13:0] clearFloor;
  logic [9:1]  clearInternal;

  int tests = 0;
  int fails = 0;

  car_motion #(.TRAVEL_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .nextDirection(nextDirection),
    .doorState(doorState), .floorButton(floorButton), .internalButton(internalButton),
    .currentFloor(currentFloor), .currentDirection(currentDirection), .move(move),
    .arrive(arrive), .clearFloor(clearFloor), .clearInternal(clearInternal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic [1:0]  nd;
    logic        door;
    logic [13:0] fb;
    logic [9:1]  ib;
    int          cyc;
    logic [2:0]  e_floor;
    logic [1:0]  e_dir;
    logic        e_move;
    logic        e_arr;
    logic [13:0] e_cf;
    logic [13:0] cf_mask;
    logic [9:1]  e_ci;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic rst, logic en, logic [1:0] nd, logic door,
                              logic [13:0] fb, logic [9:1] ib, int cyc, logic [2:0] e_floor,
                              logic [1:0] e_dir, logic e_move, logic e_arr, logic [13:0] e_cf,
                              logic [13:0] cf_mask, logic [9:1] e_ci);
    vec_t v;
    v.name = name; v.rst = rst; v.en = en; v.nd = nd; v.door = door; v.fb = fb; v.ib = ib;
    v.cyc = cyc; v.e_floor = e_floor; v.e_dir = e_dir; v.e_move = e_move; v.e_arr = e_arr;
    v.e_cf = e_cf; v.cf_mask = cf_mask; v.e_ci = e_ci;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; nextDirection = ST; doorState = 1'b0;
    floorButton = '0; internalButton = '0;
    tick(1);
    reset = 1'b0;
  endtask

  logic [9:1] ib3, ci2, ci5, ci6, ci7;

  initial begin
    ib3 = '0; ib3[3] = 1'b1;
    ci2 = '0; ci2[2] = 1'b1;
    ci5 = '0; ci5[5] = 1'b1;
    ci6 = '0; ci6[6] = 1'b1;
    ci7 = '0; ci7[7] = 1'b1;

    // name, rst,en,nd,door,fb,ib,cyc, floor,dir,move,arr,cf,cfmask,ci
    vecs.push_back(mk("reset",      1, 1, ST,    0, '0, '0,  2, 3'd1, ST, 0, 0, '0, FULL, '0));
    vecs.push_back(mk("depart",     0, 1, UP,    0, '0, ib3, 1, 3'd1, UP, 1, 0, '0, FULL, '0));
    vecs.push_back(mk("count",      0, 1, UP,    0, '0, ib3, 3, 3'd1, UP, 1, 0, '0, FULL, '0));
    vecs.push_back(mk("floor2",     0, 1, UP,    0, '0, ib3, 1, 3'd2, UP, 1, 0, '0, FULL, '0));
    vecs.push_back(mk("floor2hold", 0, 1, UP,    0, '0, ib3, 3, 3'd2, UP, 1, 0, '0, FULL, '0));
    vecs.push_back(mk("arrive3",    0, 1, UP,    0, '0, ib3, 1, 3'd3, UP, 0, 1, '0, 14'h3FDF, ib3));
    vecs.push_back(mk("settle1",    0, 1, UP,    0, '0, ib3, 1, 3'd3, UP, 0, 0, '0, FULL, '0));
    vecs.push_back(mk("settle2",    0, 1, UP,    0, '0, ib3, 1, 3'd3, UP, 0, 0, '0, FULL, '0));
    vecs.push_back(mk("redepart",   0, 1, UP,    0, '0, ib3, 1, 3'd3, UP, 1, 0, '0, FULL, '0));
    vecs.push_back(mk("reset2",     1, 1, ST,    0, '0, '0,  1, 3'd1, ST, 0, 0, '0, FULL, '0));
    vecs.push_back(mk("down_at_1",  0, 1, DN,    0, '0, '0,  3, 3'd1, ST, 0, 0, '0, FULL, '0));
    vecs.push_back(mk("updown",     0, 1, 2'b11, 0, '0, '0,  3, 3'd1, ST, 0, 0, '0, FULL, '0));
    vecs.push_back(mk("door_open",  0, 1, UP,    1, '0, '0,  3, 3'd1, ST, 0, 0, '0, FULL, '0));
    vecs.push_back(mk("door_close", 0, 1, UP,    0, '0, '0,  1, 3'd1, UP, 1, 0, '0, FULL, '0));
    vecs.push_back(mk("reset3",     1, 1, ST,    0, '0, '0,  1, 3'd1, ST, 0, 0, '0, FULL, '0));

    foreach (vecs[i]) begin
      reset = vecs[i].rst; enable = vecs[i].en; nextDirection = vecs[i].nd;
      doorState = vecs[i].door; floorButton = vecs[i].fb; internalButton = vecs[i].ib;
      tick(vecs[i].cyc);
      chk({vecs[i].name, ".floor"}, 32'(currentFloor), 32'(vecs[i].e_floor));
      chk({vecs[i].name, ".dir"},   32'(currentDirection), 32'(vecs[i].e_dir));
      chk({vecs[i].name, ".move"},  32'(move), 32'(vecs[i].e_move));
      chk({vecs[i].name, ".arrive"}, 32'(arrive), 32'(vecs[i].e_arr));
      chk({vecs[i].name, ".clrF"},  32'(clearFloor & vecs[i].cf_mask), 32'(vecs[i].e_cf));
      chk({vecs[i].name, ".clrI"},  32'(clearInternal), 32'(vecs[i].e_ci));
    end

    // Pass a down request at floor 3 while going up to floor 5
    do_reset();
    nextDirection = UP; floorButton[4] = 1'b1; internalButton[5] = 1'b1;
    tick(1);
    chk("pass.move", 32'(move), 32'd1);
    tick(8);
    chk("pass.f3",   32'(currentFloor), 32'd3);
    chk("pass.mv3",  32'(move), 32'd1);
    chk("pass.arr3", 32'(arrive), 32'd0);
    chk("pass.clr3", 32'(clearFloor), 32'd0);
    tick(8);
    chk("pass.f5",   32'(currentFloor), 32'd5);
    chk("pass.arr5", 32'(arrive), 32'd1);
    chk("pass.mv5",  32'(move), 32'd0);
    chk("pass.ci5",  32'(clearInternal), 32'(ci5));
    chk("pass.cf5",  32'(clearFloor & 14'h3DFF), 32'd0);

    // Down request at 5 with nothing beyond (car bits 8/9 ignored)
    do_reset();
    nextDirection = UP; floorButton[8] = 1'b1; internalButton[8] = 1'b1; internalButton[9] = 1'b1;
    tick(13);
    chk("nobey.f4",  32'(currentFloor), 32'd4);
    chk("nobey.mv4", 32'(move), 32'd1);
    tick(4);
    chk("nobey.f5",  32'(currentFloor), 32'd5);
    chk("nobey.arr", 32'(arrive), 32'd1);
    chk("nobey.cf",  32'(clearFloor), 32'h0300);
    chk("nobey.ci",  32'(clearInternal), 32'(ci5));

    // Up request at 2 with a car request further up
    do_reset();
    nextDirection = UP; floorButton[3] = 1'b1; internalButton[6] = 1'b1;
    tick(5);
    chk("hall.f2",  32'(currentFloor), 32'd2);
    chk("hall.arr", 32'(arrive), 32'd1);
    chk("hall.cf",  32'(clearFloor), 32'h0008);
    chk("hall.ci",  32'(clearInternal), 32'(ci2));

    // Run to the top endpoint, then one floor down
    do_reset();
    nextDirection = UP;
    tick(21);
    chk("top.f6",  32'(currentFloor), 32'd6);
    chk("top.mv6", 32'(move), 32'd1);
    tick(4);
    chk("top.f7",  32'(currentFloor), 32'd7);
    chk("top.arr", 32'(arrive), 32'd1);
    chk("top.mv",  32'(move), 32'd0);
    chk("top.cf",  32'(clearFloor), 32'h3000);
    chk("top.ci",  32'(clearInternal), 32'(ci7));
    nextDirection = DN; internalButton[6] = 1'b1;
    tick(2);
    chk("down.settle", 32'(move), 32'd0);
    tick(1);
    chk("down.move", 32'(move), 32'd1);
    chk("down.dir",  32'(currentDirection), 32'(DN));
    tick(4);
    chk("down.f6",  32'(currentFloor), 32'd6);
    chk("down.arr", 32'(arrive), 32'd1);
    chk("down.ci",  32'(clearInternal), 32'(ci6));
    chk("down.cf",  32'(clearFloor & 14'h3BFF), 32'd0);
    tick(1);
    chk("down.keepdir", 32'(currentDirection), 32'(DN));
    chk("down.pulse",   32'(arrive), 32'd0);

    // Stall mid-travel with enable low, then reset while moving
    do_reset();
    nextDirection = UP; internalButton[5] = 1'b1;
    tick(5);
    chk("stall.f2", 32'(currentFloor), 32'd2);
    tick(1);
    enable = 1'b0;
    tick(5);
    chk("stall.frozen", 32'(currentFloor), 32'd2);
    chk("stall.mv",     32'(move), 32'd1);
    enable = 1'b1;
    tick(2);
    chk("stall.late", 32'(currentFloor), 32'd2);
    tick(1);
    chk("stall.f3",   32'(currentFloor), 32'd3);
    chk("stall.mv3",  32'(move), 32'd1);
    reset = 1'b1;
    tick(1);
    chk("rstmid.floor", 32'(currentFloor), 32'd1);
    chk("rstmid.move",  32'(move), 32'd0);
    chk("rstmid.dir",   32'(currentDirection), 32'(ST));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
